// File: rtl/logic_bist_pkg.sv
// logic_bist_pkg: shared op and FSM state encodings for the logic BIST block.
package logic_bist_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
   typedef enum logic [2:0] {
      OP_OR   = 3'd0,
      OP_NOTA = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XNOR = 3'd4,
      OP_XOR  = 3'd5,
      OP_AND  = 3'd6,
      OP_BUFA = 3'd7
   } op_e;
endpackage

// File: rtl/logic_unit.sv
// logic_unit: bitwise gate function under test, selected by op.
module logic_unit
   import logic_bist_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y
);
   always_comb begin
      case (op_e'(op))
         OP_OR:   y = a | b;
         OP_NOTA: y = ~a;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_XOR:  y = a ^ b;
         OP_AND:  y = a & b;
         default: y = a;
      endcase
   end
endmodule

// File: rtl/logic_bist.sv
// logic_bist: exhaustive vector sweep of logic_unit with MISR signature compaction.
module logic_bist
   import logic_bist_pkg::*;
#(
   parameter int               WIDTH = 2,
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = 16'h1021,
   parameter logic [SIG_W-1:0] SEED  = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [SIG_W-1:0] expected,
   output logic [WIDTH-1:0] vec_a,
   output logic [WIDTH-1:0] vec_b,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);
   localparam int CW = 2 * WIDTH;
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SIG_W-1:0] sig_q, sig_d, exp_q, exp_d;
   logic [2:0]       op_q, op_d;
   logic             pass_q, pass_d, done_q, start_q, go, last;
   // start is edge-qualified so a held request yields a single run
   assign go        = start & ~start_q;
   assign last      = &cnt_q;
   assign {vec_a, vec_b} = cnt_q;
   assign signature = sig_q;
   assign pass      = pass_q;
   assign done      = done_q;
   logic_unit #(.WIDTH(WIDTH)) u_logic_unit (.a(vec_a), .b(vec_b), .op(op_q), .y(result));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = go ? RUN : IDLE;
         RUN:     state_d = last ? DONE : RUN;
         default: state_d = IDLE;
      endcase
   end
   always_comb busy = (state_q != IDLE);
   always_comb begin
      cnt_d  = cnt_q;
      sig_d  = sig_q;
      op_d   = op_q;
      exp_d  = exp_q;
      pass_d = pass_q;
      if (state_q == IDLE && go) begin
         cnt_d  = '0;
         sig_d  = SEED;
         op_d   = op;
         exp_d  = expected;
         pass_d = 1'b0;
      end else if (state_q == RUN) begin
         cnt_d = cnt_q + CW'(1);
         sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(result);
      end else if (state_q == DONE) begin
         pass_d = (sig_q == exp_q);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         sig_q   <= SEED;
         op_q    <= '0;
         exp_q   <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sig_q   <= sig_d;
         op_q    <= op_d;
         exp_q   <= exp_d;
         pass_q  <= pass_d;
         done_q  <= (state_q == DONE);
         start_q <= start;
      end
   end
endmodule

// File: tb/tb_logic_bist.sv
// tb_logic_bist: scoreboard bench for logic_bist at WIDTH=1 and WIDTH=2.
module tb_logic_bist;
   typedef struct {
      logic [3:0]  a;
      logic [3:0]  b;
      logic [3:0]  r;
      logic [15:0] s;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start1, start2;
   logic [2:0]  op1, op2;
   logic [15:0] ex1, ex2;
   logic        va1, vb1, r1;
   logic [1:0]  va2, vb2, r2;
   logic        busy1, done1, pass1, busy2, done2, pass2;
   logic [15:0] sig1, sig2;
   int          n_chk = 0;
   int          n_pass = 0;
   exp_t        q1[$], q2[$];
   exp_t        e1, e2;
   always #5 clk = ~clk;
   logic_bist #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .expected(ex1),
      .vec_a(va1), .vec_b(vb1), .result(r1), .busy(busy1), .done(done1),
      .pass(pass1), .signature(sig1)
   );
   logic_bist #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .expected(ex2),
      .vec_a(va2), .vec_b(vb2), .result(r2), .busy(busy2), .done(done2),
      .pass(pass2), .signature(sig2)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
      else n_pass++;
   endtask
   function automatic logic [3:0] ref_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input int w);
      logic [3:0] y;
      case (o)
         3'd0:    y = a | b;
         3'd1:    y = ~a;
         3'd2:    y = ~(a & b);
         3'd3:    y = ~(a | b);
         3'd4:    y = ~(a ^ b);
         3'd5:    y = a ^ b;
         3'd6:    y = a & b;
         default: y = a;
      endcase
      return y & 4'((1 << w) - 1);
   endfunction
   function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] r);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, r};
   endfunction
   function automatic logic [15:0] model_sig(input int w, input logic [2:0] o);
      logic [15:0] s = 16'hFFFF;
      for (int i = 0; i < (1 << (2 * w)); i++)
         s = misr(s, ref_op(o, 4'(i >> w), 4'(i & ((1 << w) - 1)), w));
      return s;
   endfunction
   always @(negedge clk) begin
      if (busy1 && q1.size() > 0) begin
         e1 = q1.pop_front();
         check("vec_w1", {29'd0, va1, vb1, r1}, {29'd0, e1.a[0], e1.b[0], e1.r[0]});
         check("sig_w1", {16'd0, sig1}, {16'd0, e1.s});
      end
      if (busy2 && q2.size() > 0) begin
         e2 = q2.pop_front();
         check("vec_w2", {26'd0, va2, vb2, r2}, {26'd0, e2.a[1:0], e2.b[1:0], e2.r[1:0]});
         check("sig_w2", {16'd0, sig2}, {16'd0, e2.s});
      end
   end
   task automatic run(input int w, input logic [2:0] o, input logic [15:0] ex, input int hold,
                      input bit swap, input bit want_pass);
      int          n = 1 << (2 * w);
      logic [15:0] s = 16'hFFFF;
      int          kd = -1;
      int          nd = 0;
      int          nb = 0;
      logic        pg = 1'b0;
      logic [15:0] sg = 16'h0;
      exp_t        e;
      for (int i = 0; i < n; i++) begin
         e.a = 4'(i >> w);
         e.b = 4'(i & ((1 << w) - 1));
         e.r = ref_op(o, e.a, e.b, w);
         e.s = s;
         if (w == 1) q1.push_back(e);
         else q2.push_back(e);
         s = misr(s, e.r);
      end
      if (w == 1) begin start1 = 1'b1; op1 = o; ex1 = ex; end
      else begin start2 = 1'b1; op2 = o; ex2 = ex; end
      for (int k = 0; k < hold + n + 4; k++) begin
         @(posedge clk); #1;
         if (k + 1 >= hold) begin start1 = 1'b0; start2 = 1'b0; end
         if (swap && k == 1) begin op1 = 3'd0; op2 = 3'd0; ex1 = ~ex; ex2 = ~ex; end
         nb += int'(w == 1 ? busy1 : busy2);
         if (w == 1 ? done1 : done2) begin
            nd++;
            if (kd < 0) begin
               kd = k;
               pg = (w == 1) ? pass1 : pass2;
               sg = (w == 1) ? sig1 : sig2;
            end
         end
      end
      check("latency", kd, n + 1);
      check("done_pulses", nd, 1);
      check("busy_cycles", nb, n + 1);
      check("pass", {31'd0, pg}, {31'd0, want_pass});
      check("final_sig", {16'd0, sg}, {16'd0, s});
      check("pass_hold", {31'd0, (w == 1) ? pass1 : pass2}, {31'd0, want_pass});
      check("sig_hold", {16'd0, (w == 1) ? sig1 : sig2}, {16'd0, s});
      check("drained", (w == 1) ? q1.size() : q2.size(), 0);
   endtask
   initial begin
      int          nd;
      logic [15:0] sx;
      rst_n = 1'b0;
      start1 = 1'b0; start2 = 1'b0;
      op1 = 3'd0; op2 = 3'd0;
      ex1 = 16'h0; ex2 = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {30'd0, busy1, busy2}, 32'd0);
      check("rst_done", {30'd0, done1, done2}, 32'd0);
      check("rst_pass", {30'd0, pass1, pass2}, 32'd0);
      check("rst_sig", {sig1, sig2}, 32'hFFFF_FFFF);
      check("rst_vec", {26'd0, va1, vb1, va2, vb2}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      sx = model_sig(1, 3'd5);
      run(1, 3'd5, sx, 1, 1'b0, 1'b1);
      run(1, 3'd5, sx ^ 16'h0001, 1, 1'b0, 1'b0);
      for (int o = 0; o < 8; o++) run(2, 3'(o), model_sig(2, 3'(o)), 1, 1'b0, 1'b1);
      run(1, 3'd5, sx, 10, 1'b0, 1'b1);
      run(1, 3'd5, sx, 1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) q2.push_back('{4'(i >> 2), 4'(i & 3), ref_op(3'd6, 4'(i >> 2), 4'(i & 3), 2),
                                                  16'h0});
      sx = 16'hFFFF;
      foreach (q2[i]) begin q2[i].s = sx; sx = misr(sx, q2[i].r); end
      start2 = 1'b1; op2 = 3'd6; ex2 = 16'h0;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int k = 0; k < 10 && {va2, vb2} != 4'd3; k++) begin
         @(posedge clk); #1;
      end
      check("mid_cnt", {28'd0, va2, vb2}, 32'd3);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy2}, 32'd0);
      check("abort_sig", {16'd0, sig2}, 32'h0000_FFFF);
      q2.delete();
      nd = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         nd += int'(done2);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         nd += int'(done2);
      end
      check("abort_no_done", nd, 0);
      check("abort_idle", {31'd0, busy2}, 32'd0);
      run(2, 3'd5, model_sig(2, 3'd5), 1, 1'b0, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
